// File: rtl/tlb_assoc_rr_if.sv
// Lookup, fill, invalidate and flush bundle for tlb_assoc_rr; names are from the TLB's point of view.
// TLB_PERF_CNT_EN adds the per-channel hit/miss counter outputs.
interface tlb_assoc_rr_if #(
    parameter int VPN_W     = 20,
    parameter int PTE_W     = 24,
    parameter int IDX_W     = 3,
    parameter int NUM_PORTS = 4
);
    logic [NUM_PORTS-1:0]       i_lkp_valid;
    logic [NUM_PORTS*VPN_W-1:0] i_lkp_vpn;
    logic [NUM_PORTS-1:0]       o_rsp_valid;
    logic [NUM_PORTS-1:0]       o_rsp_hit;
    logic [NUM_PORTS*PTE_W-1:0] o_rsp_pte;
    logic [NUM_PORTS*IDX_W-1:0] o_rsp_idx;
    logic                       i_fill_valid;
    logic                       o_fill_ready;
    logic [VPN_W-1:0]           i_fill_vpn;
    logic [PTE_W-1:0]           i_fill_pte;
    logic                       i_inv_valid;
    logic [VPN_W-1:0]           i_inv_vpn;
    logic                       i_flush;
`ifdef TLB_PERF_CNT_EN
    logic [NUM_PORTS*16-1:0]    o_hit_cnt;
    logic [NUM_PORTS*16-1:0]    o_miss_cnt;
`endif

    modport slave (
        input  i_lkp_valid, i_lkp_vpn, i_fill_valid, i_fill_vpn, i_fill_pte,
               i_inv_valid, i_inv_vpn, i_flush,
        output o_rsp_valid, o_rsp_hit, o_rsp_pte, o_rsp_idx, o_fill_ready
`ifdef TLB_PERF_CNT_EN
        , output o_hit_cnt, o_miss_cnt
`endif
    );

    modport master (
        output i_lkp_valid, i_lkp_vpn, i_fill_valid, i_fill_vpn, i_fill_pte,
               i_inv_valid, i_inv_vpn, i_flush,
        input  o_rsp_valid, o_rsp_hit, o_rsp_pte, o_rsp_idx, o_fill_ready
`ifdef TLB_PERF_CNT_EN
        , input o_hit_cnt, o_miss_cnt
`endif
    );
endinterface

// File: rtl/tlb_assoc_rr.sv
// Fully-associative TLB, multi-channel registered lookup, fill with round-robin eviction, invalidate, flush.
// Optional per-channel saturating hit/miss counters when TLB_PERF_CNT_EN is defined.
module tlb_assoc_rr #(
    parameter int VPN_W     = 20,
    parameter int PTE_W     = 24,
    parameter int DEPTH     = 8,
    parameter int IDX_W     = 3,
    parameter int NUM_PORTS = 4
) (
    input logic           clk,
    input logic           rst,
    tlb_assoc_rr_if.slave bus
);
    logic [VPN_W-1:0] r_vpn [DEPTH];
    logic [PTE_W-1:0] r_pte [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [IDX_W-1:0] r_vptr;

    logic [NUM_PORTS-1:0]       r_rsp_valid;
    logic [NUM_PORTS-1:0]       r_rsp_hit;
    logic [NUM_PORTS*PTE_W-1:0] r_rsp_pte;
    logic [NUM_PORTS*IDX_W-1:0] r_rsp_idx;

    logic [NUM_PORTS-1:0] w_hit;
    logic [PTE_W-1:0]     w_pte [NUM_PORTS];
    logic [IDX_W-1:0]     w_idx [NUM_PORTS];

    logic [DEPTH-1:0] w_inv_clr;
    logic [DEPTH-1:0] w_valid_post;
    logic             w_fill_accept;
    logic             w_fill_match;
    logic [IDX_W-1:0] w_fill_match_idx;
    logic             w_has_free;
    logic [IDX_W-1:0] w_free_idx;
    logic [IDX_W-1:0] w_fill_idx;
    logic             w_evict;
    logic [DEPTH-1:0] w_fill_onehot;

    // Descending scan so the lowest matching index is the one that sticks.
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            w_hit[p] = 1'b0;
            w_pte[p] = '0;
            w_idx[p] = '0;
            if (bus.i_lkp_valid[p]) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (r_valid[k] && (r_vpn[k] == bus.i_lkp_vpn[p*VPN_W +: VPN_W])) begin
                        w_hit[p] = 1'b1;
                        w_pte[p] = r_pte[k];
                        w_idx[p] = IDX_W'(k);
                    end
                end
            end
        end
    end

    // Fill placement looks at the valid bits after this cycle's invalidate.
    always_comb begin
        w_inv_clr        = '0;
        w_fill_match     = 1'b0;
        w_fill_match_idx = '0;
        w_has_free       = 1'b0;
        w_free_idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_inv_clr[k] = bus.i_inv_valid && r_valid[k] && (r_vpn[k] == bus.i_inv_vpn);
        end
        w_valid_post = r_valid & ~w_inv_clr;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (w_valid_post[k] && (r_vpn[k] == bus.i_fill_vpn)) begin
                w_fill_match     = 1'b1;
                w_fill_match_idx = IDX_W'(k);
            end
            if (!w_valid_post[k]) begin
                w_has_free = 1'b1;
                w_free_idx = IDX_W'(k);
            end
        end
        w_evict    = !w_fill_match && !w_has_free;
        w_fill_idx = w_fill_match ? w_fill_match_idx : (w_has_free ? w_free_idx : r_vptr);
    end

    assign bus.o_fill_ready = ~bus.i_flush & ~rst;
    assign w_fill_accept    = bus.i_fill_valid & bus.o_fill_ready;
    assign w_fill_onehot    = w_fill_accept ? (DEPTH'(1) << w_fill_idx) : '0;

    always_ff @(posedge clk) begin
        if (w_fill_accept) begin
            r_vpn[w_fill_idx] <= bus.i_fill_vpn;
            r_pte[w_fill_idx] <= bus.i_fill_pte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_vptr  <= '0;
        end else if (bus.i_flush) begin
            r_valid <= '0;
            r_vptr  <= '0;
        end else begin
            r_valid <= w_valid_post | w_fill_onehot;
            if (w_fill_accept && w_evict) begin
                r_vptr <= r_vptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= '0;
            r_rsp_hit   <= '0;
            r_rsp_pte   <= '0;
            r_rsp_idx   <= '0;
        end else begin
            r_rsp_valid <= bus.i_lkp_valid;
            r_rsp_hit   <= w_hit;
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_rsp_pte[p*PTE_W +: PTE_W] <= w_pte[p];
                r_rsp_idx[p*IDX_W +: IDX_W] <= w_idx[p];
            end
        end
    end

    assign bus.o_rsp_valid = r_rsp_valid;
    assign bus.o_rsp_hit   = r_rsp_hit;
    assign bus.o_rsp_pte   = r_rsp_pte;
    assign bus.o_rsp_idx   = r_rsp_idx;

`ifdef TLB_PERF_CNT_EN
    logic [NUM_PORTS*16-1:0] r_hit_cnt;
    logic [NUM_PORTS*16-1:0] r_miss_cnt;

    // Counters saturate rather than wrap so long runs stay meaningful.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (bus.i_flush) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bus.i_lkp_valid[p] && w_hit[p] && (r_hit_cnt[p*16 +: 16] != 16'hFFFF)) begin
                    r_hit_cnt[p*16 +: 16] <= r_hit_cnt[p*16 +: 16] + 16'd1;
                end
                if (bus.i_lkp_valid[p] && !w_hit[p] && (r_miss_cnt[p*16 +: 16] != 16'hFFFF)) begin
                    r_miss_cnt[p*16 +: 16] <= r_miss_cnt[p*16 +: 16] + 16'd1;
                end
            end
        end
    end

    assign bus.o_hit_cnt  = r_hit_cnt;
    assign bus.o_miss_cnt = r_miss_cnt;
`else
    // Default build carries no performance counters.
`endif
endmodule

// File: tb/tb_tlb_assoc_rr.sv
// Directed self-checking bench for tlb_assoc_rr: lookup, fill placement, eviction order, invalidate, flush, reset.
module tb_tlb_assoc_rr;
    localparam int VPN_W     = 20;
    localparam int PTE_W     = 24;
    localparam int DEPTH     = 8;
    localparam int IDX_W     = 3;
    localparam int NUM_PORTS = 4;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    tlb_assoc_rr_if #(.VPN_W(VPN_W), .PTE_W(PTE_W), .IDX_W(IDX_W), .NUM_PORTS(NUM_PORTS)) bus ();

    tlb_assoc_rr #(
        .VPN_W(VPN_W), .PTE_W(PTE_W), .DEPTH(DEPTH), .IDX_W(IDX_W), .NUM_PORTS(NUM_PORTS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [79:0] lkp4(input logic [19:0] v0, input logic [19:0] v1,
                                         input logic [19:0] v2, input logic [19:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic applyStimulus(input logic [3:0] lkpValid, input logic [79:0] lkpVpn,
                                 input logic fillValid, input logic [19:0] fillVpn,
                                 input logic [23:0] fillPte, input logic invValid,
                                 input logic [19:0] invVpn, input logic flush);
        bus.i_lkp_valid  = lkpValid;
        bus.i_lkp_vpn    = lkpVpn;
        bus.i_fill_valid = fillValid;
        bus.i_fill_vpn   = fillVpn;
        bus.i_fill_pte   = fillPte;
        bus.i_inv_valid  = invValid;
        bus.i_inv_vpn    = invVpn;
        bus.i_flush      = flush;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkRsp(input string tag, input logic [3:0] valid, input logic [3:0] hit,
                            input logic [95:0] pte, input logic [11:0] idx);
        checkOutput({tag, ".valid"}, bus.o_rsp_valid, valid);
        checkOutput({tag, ".hit"},   bus.o_rsp_hit,   hit);
        checkOutput({tag, ".pte"},   bus.o_rsp_pte,   pte);
        checkOutput({tag, ".idx"},   bus.o_rsp_idx,   idx);
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(4'h0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        repeat (2) tick();
        checkRsp("reset", 4'h0, 4'h0, '0, '0);
        checkOutput("reset.fill_ready", bus.o_fill_ready, 1'b0);
`ifdef TLB_PERF_CNT_EN
        checkOutput("reset.hit_cnt", bus.o_hit_cnt, '0);
        checkOutput("reset.miss_cnt", bus.o_miss_cnt, '0);
`endif
        rst = 1'b0;
        #1;
        checkOutput("post_reset.fill_ready", bus.o_fill_ready, 1'b1);

        applyStimulus(4'hF, lkp4(20'h02000, 20'h02000, 20'h02000, 20'h02000), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("empty_lookup", 4'hF, 4'h0, '0, '0);
        applyStimulus(4'h0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("idle.valid", bus.o_rsp_valid, 4'h0);

        applyStimulus(4'h0, '0, 1'b1, 20'h02000, 24'h000022, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'h0, '0, 1'b1, 20'h0b000, 24'h00004E, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'b0111, lkp4(20'h02000, 20'h0b000, 20'h12345, 20'h02000), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("two_fills", 4'b0111, 4'b0011,
                 {24'h0, 24'h0, 24'h00004E, 24'h000022}, {3'd0, 3'd0, 3'd1, 3'd0});

        applyStimulus(4'b0010, lkp4(20'h0, 20'h0b000, 20'h0, 20'h0), 1'b1, 20'h0b000, 24'h00007E, 1'b0, '0, 1'b0);
        tick();
        checkRsp("refill_same_cycle", 4'b0010, 4'b0010, {24'h0, 24'h0, 24'h00004E, 24'h0}, {3'd0, 3'd0, 3'd1, 3'd0});
        applyStimulus(4'b0011, lkp4(20'h02000, 20'h0b000, 20'h0, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("refill_after", 4'b0011, 4'b0011, {24'h0, 24'h0, 24'h00007E, 24'h000022}, {3'd0, 3'd0, 3'd1, 3'd0});

        applyStimulus(4'b0001, lkp4(20'h02000, 20'h0, 20'h0, 20'h0), 1'b1, 20'h00000, 24'h000100, 1'b1, 20'h02000, 1'b1);
        #1;
        checkOutput("flush.fill_ready", bus.o_fill_ready, 1'b0);
        tick();
        checkRsp("flush_cycle_lookup", 4'b0001, 4'b0001, {72'h0, 24'h000022}, '0);
        applyStimulus(4'b0111, lkp4(20'h02000, 20'h0b000, 20'h00000, 20'h0), 1'b1, 20'h00000, 24'h000100, 1'b0, '0, 1'b0);
        #1;
        checkOutput("after_flush.fill_ready", bus.o_fill_ready, 1'b1);
        tick();
        checkRsp("after_flush", 4'b0111, 4'b0000, '0, '0);
        applyStimulus(4'b0100, lkp4(20'h0, 20'h0, 20'h00000, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("held_fill_taken", 4'b0100, 4'b0100, {24'h0, 24'h000100, 48'h0}, '0);

        for (int k = 1; k <= 8; k++) begin
            applyStimulus(4'h0, '0, 1'b1, 20'(k), 24'h000100 + 24'(k), 1'b0, '0, 1'b0);
            tick();
        end
        applyStimulus(4'hF, lkp4(20'h00000, 20'h00008, 20'h00007, 20'h00001), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("evict_first", 4'hF, 4'b1110,
                 {24'h000101, 24'h000107, 24'h000108, 24'h0}, {3'd1, 3'd7, 3'd0, 3'd0});

        applyStimulus(4'h0, '0, 1'b1, 20'h00009, 24'h000109, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'h0, '0, 1'b1, 20'h00005, 24'h0001F5, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'h0, '0, 1'b1, 20'h0000A, 24'h00010A, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'hF, lkp4(20'h00001, 20'h0000A, 20'h00005, 20'h00009), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("vptr_order", 4'hF, 4'b1110,
                 {24'h000109, 24'h0001F5, 24'h00010A, 24'h0}, {3'd1, 3'd5, 3'd2, 3'd0});

        applyStimulus(4'b0001, lkp4(20'h00003, 20'h0, 20'h0, 20'h0), 1'b0, '0, '0, 1'b1, 20'h00003, 1'b0);
        tick();
        checkRsp("inv_same_cycle", 4'b0001, 4'b0001, {72'h0, 24'h000103}, {9'd0, 3'd3});
        applyStimulus(4'h0, '0, 1'b1, 20'h0000B, 24'h00010B, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'h0, '0, 1'b1, 20'h0000C, 24'h00010C, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'hF, lkp4(20'h00003, 20'h0000B, 20'h0000C, 20'h00004), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("inv_then_fill", 4'hF, 4'b1100,
                 {24'h000104, 24'h00010C, 48'h0}, {3'd4, 3'd3, 3'd0, 3'd0});

        applyStimulus(4'h0, '0, 1'b1, 20'h0000C, 24'h000555, 1'b1, 20'h0000C, 1'b0);
        tick();
        applyStimulus(4'b0011, lkp4(20'h0000C, 20'h00004, 20'h0, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("inv_fill_same_vpn", 4'b0011, 4'b0011,
                 {48'h0, 24'h000104, 24'h000555}, {3'd0, 3'd0, 3'd4, 3'd3});
        applyStimulus(4'h0, '0, 1'b1, 20'h0000D, 24'h00010D, 1'b0, '0, 1'b0);
        tick();
        applyStimulus(4'b0011, lkp4(20'h00004, 20'h0000D, 20'h0, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("vptr_kept", 4'b0011, 4'b0010,
                 {48'h0, 24'h00010D, 24'h0}, {3'd0, 3'd0, 3'd4, 3'd0});

        applyStimulus(4'b0001, lkp4(20'h0000D, 20'h0, 20'h0, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkOutput("pre_rst.hit", bus.o_rsp_hit, 4'b0001);
        #2;
        rst = 1'b1;
        #1;
        checkRsp("async_rst", 4'h0, 4'h0, '0, '0);
        tick();
        rst = 1'b0;
        applyStimulus(4'b0011, lkp4(20'h0000D, 20'h0000C, 20'h0, 20'h0), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        checkRsp("after_rst", 4'b0011, 4'b0000, '0, '0);
`ifdef TLB_PERF_CNT_EN
        checkOutput("after_rst.hit_cnt", bus.o_hit_cnt, '0);
        checkOutput("after_rst.miss_cnt", bus.o_miss_cnt, {32'h0, 16'd1, 16'd1});
`endif

        applyStimulus(4'h0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
